// File: rtl/piso_serializer_if.sv
// -----------------------------------------------------------------------------
// piso_serializer_if
// Bundles the parallel load handshake and the serial output of the
// piso_serializer.
//   load_data   WIDTH  parallel word to serialize (producer -> serializer)
//   load_valid  1      load_data is valid         (producer -> serializer)
//   load_ready  1      serializer accepts a word  (serializer -> producer)
//   sd          1      serial data bit, feeds the downstream delay line
//   sd_valid    1      sd carries a data bit this cycle
//   busy        1      serializer is shifting or in its idle gap
//   frame_done  1      one-cycle pulse after the last bit of a word
// master = word producer / serial consumer, slave = the serializer.
// -----------------------------------------------------------------------------
interface piso_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             sd;
  logic             sd_valid;
  logic             busy;
  logic             frame_done;

  modport master (
    output load_data,
    output load_valid,
    input  load_ready,
    input  sd,
    input  sd_valid,
    input  busy,
    input  frame_done
  );

  modport slave (
    input  load_data,
    input  load_valid,
    output load_ready,
    output sd,
    output sd_valid,
    output busy,
    output frame_done
  );
endinterface : piso_serializer_if

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
// Parallel-in / serial-out serializer. Accepts a WIDTH-bit word over a
// valid/ready handshake, shifts it out one bit per clock with sd_valid high,
// then holds sd at IDLE_LEVEL for GAP_CYCLES cycles before accepting the next
// word. With GAP_CYCLES == 0 a word offered during the last bit is taken
// without a bubble.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    piso_serializer_if.slave (load_data/valid/ready, sd, sd_valid,
//          busy, frame_done)
// Parameters: WIDTH (2..32), LSB_FIRST, GAP_CYCLES (0..15), IDLE_LEVEL.
// -----------------------------------------------------------------------------
module piso_serializer #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          LSB_FIRST  = 1'b0,
  parameter int unsigned GAP_CYCLES = 1,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  piso_serializer_if.slave bus
);

  localparam int unsigned     CNT_W        = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT    = CNT_W'(WIDTH - 1);
  localparam logic [3:0]      GAP_LOAD     = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
  localparam bit              BACK_TO_BACK = (GAP_CYCLES == 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state_q,     state_d;
  logic [WIDTH-1:0] sreg_q,      sreg_d;
  logic [CNT_W-1:0] bit_cnt_q,   bit_cnt_d;
  logic [3:0]       gap_cnt_q,   gap_cnt_d;
  logic             frame_done_q, frame_done_d;

  logic             last_bit;
  logic             load_ready;
  logic             accept;
  logic             head;
  logic [WIDTH-1:0] shifted;

  // Head bit is the one currently presented on sd; the register moves
  // toward the head so the next bit is in place after each edge.
  assign head    = LSB_FIRST ? sreg_q[0] : sreg_q[WIDTH-1];
  assign shifted = LSB_FIRST ? {1'b0, sreg_q[WIDTH-1:1]}
                             : {sreg_q[WIDTH-2:0], 1'b0};

  assign last_bit   = (state_q == ST_SHIFT) && (bit_cnt_q == '0);
  // Decoded from registered state only, never from load_valid, so the
  // producer sees no combinational loop through the handshake.
  assign load_ready = (state_q == ST_IDLE) || (BACK_TO_BACK && last_bit);
  assign accept     = bus.load_valid && load_ready;

  // NOTE: every variable written here gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d      = state_q;
    sreg_d       = sreg_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          sreg_d    = bus.load_data;
          bit_cnt_d = LAST_BIT;
          state_d   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (bit_cnt_q == '0) begin
          // Final bit is on sd this cycle: pulse frame_done next cycle,
          // even when a back-to-back word is being taken.
          frame_done_d = 1'b1;
          if (accept) begin
            sreg_d    = bus.load_data;
            bit_cnt_d = LAST_BIT;
          end else if (!BACK_TO_BACK) begin
            gap_cnt_d = GAP_LOAD;
            state_d   = ST_GAP;
          end else begin
            state_d   = ST_IDLE;
          end
        end else begin
          sreg_d    = shifted;
          bit_cnt_d = bit_cnt_q - CNT_W'(1);
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sreg_q       <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Outputs decode registered state only, so an asynchronous reset forces
  // them to their idle values in the same cycle.
  assign bus.sd         = (state_q == ST_SHIFT) ? head : IDLE_LEVEL;
  assign bus.sd_valid   = (state_q == ST_SHIFT);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.frame_done = frame_done_q;
  assign bus.load_ready = load_ready;

endmodule : piso_serializer

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
// Three serializer configurations share one clock and reset:
//   sel 0: MSB first, GAP_CYCLES=1      sel 1: LSB first, GAP_CYCLES=1
//   sel 2: MSB first, GAP_CYCLES=0
// A 4-stage delay line on the sel 0 output stands in for the downstream
// shiftreg. Inputs change 1 time unit after posedge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst_n;
  int         sel;
  logic       lv;
  logic [7:0] ld;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(8)) ia ();
  piso_serializer_if #(.WIDTH(8)) ib ();
  piso_serializer_if #(.WIDTH(8)) ic ();

  assign ia.load_valid = lv && (sel == 0);
  assign ib.load_valid = lv && (sel == 1);
  assign ic.load_valid = lv && (sel == 2);
  assign ia.load_data  = ld;
  assign ib.load_data  = ld;
  assign ic.load_data  = ld;

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .GAP_CYCLES(1), .IDLE_LEVEL(1'b0))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .GAP_CYCLES(1), .IDLE_LEVEL(1'b0))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));
  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(ic.slave));

  // Downstream 4-stage delay line model fed by dut_a.
  logic [3:0] dl;
  logic       q, q_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dl <= '0;
    else        dl <= {dl[2:0], ia.sd};
  end
  assign q   = dl[3];
  assign q_n = ~dl[3];

  // Outputs of the selected instance.
  logic m_sd, m_sdv, m_busy, m_fd, m_ready;
  always_comb begin
    m_sd = ia.sd; m_sdv = ia.sd_valid; m_busy = ia.busy;
    m_fd = ia.frame_done; m_ready = ia.load_ready;
    case (sel)
      1: begin
        m_sd = ib.sd; m_sdv = ib.sd_valid; m_busy = ib.busy;
        m_fd = ib.frame_done; m_ready = ib.load_ready;
      end
      2: begin
        m_sd = ic.sd; m_sdv = ic.sd_valid; m_busy = ic.busy;
        m_fd = ic.frame_done; m_ready = ic.load_ready;
      end
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One word through the selected instance. The stream is recorded first bit
  // in the MSB of got. load_data is altered mid-word and must be ignored.
  task automatic run_word(input int s, input logic [7:0] w, input logic [7:0] exp);
    logic [7:0] got;
    logic       all_valid, fd_seen, ready_seen;
    sel = s; ld = w; lv = 1'b1;
    #1;
    check("ready_before", m_ready, 1);
    step();                       // cycle N+1
    lv = 1'b0;
    got = '0; all_valid = 1'b1; fd_seen = 1'b0; ready_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) ld = ~w;
      got        = {got[6:0], m_sd};
      all_valid  = all_valid & m_sdv & m_busy;
      fd_seen    = fd_seen | m_fd;
      if (i < 7) ready_seen = ready_seen | m_ready;
      step();
    end
    // cycle N+9
    check("stream", got, exp);
    check("sd_valid_run", all_valid, 1);
    check("fd_early", fd_seen, 0);
    check("ready_in_shift", ready_seen, 0);
    check("frame_done", m_fd, 1);
    check("sd_valid_after", m_sdv, 0);
    check("sd_idle_after", m_sd, 0);
    if (s == 2) begin
      check("busy_after_g0", m_busy, 0);
      check("ready_after_g0", m_ready, 1);
    end else begin
      check("busy_in_gap", m_busy, 1);
      check("ready_in_gap", m_ready, 0);
      step();                     // cycle N+10
      check("ready_after_gap", m_ready, 1);
      check("busy_after_gap", m_busy, 0);
      check("fd_single", m_fd, 0);
    end
  endtask

  typedef struct {
    int         sel;
    logic [7:0] word;
    logic [7:0] stream;
  } vec_t;

  initial begin
    vec_t       vecs[5];
    logic [15:0] got16;
    logic        fd_bad, valid_all, fd_any, q_early;

    vecs[0] = '{sel: 0, word: 8'hA5, stream: 8'b1010_0101};
    vecs[1] = '{sel: 0, word: 8'h3C, stream: 8'b0011_1100};
    vecs[2] = '{sel: 1, word: 8'h01, stream: 8'b1000_0000};
    vecs[3] = '{sel: 1, word: 8'hC4, stream: 8'b0010_0011};
    vecs[4] = '{sel: 2, word: 8'h5A, stream: 8'b0101_1010};

    // Reset with load_valid held high.
    rst_n = 1'b0; sel = 0; lv = 1'b1; ld = 8'hA5;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sd", ia.sd, 0);
    check("rst_sd_valid", ia.sd_valid, 0);
    check("rst_busy", ia.busy, 0);
    check("rst_ready", ia.load_ready, 1);
    check("rst_frame_done", ia.frame_done, 0);
    rst_n = 1'b1;
    step();
    check("post_rst_handshake", {ia.busy, ia.sd_valid, ia.sd}, 3'b111);
    lv = 1'b0;
    repeat (12) step();
    check("post_rst_idle", {ia.busy, ia.load_ready}, 2'b01);

    // Table-driven single words.
    for (int v = 0; v < 5; v++) begin
      run_word(vecs[v].sel, vecs[v].word, vecs[v].stream);
      step();
    end

    // Back-to-back words with load_valid held high, no gap.
    sel = 2; ld = 8'hF0; lv = 1'b1;
    step();                       // cycle N+1
    ld = 8'h0F;
    got16 = '0; fd_bad = 1'b0; valid_all = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i < 16) begin
        got16     = {got16[14:0], m_sd};
        valid_all = valid_all & m_sdv;
      end
      if (i == 7) check("b2b_ready_last", m_ready, 1);
      if (m_fd !== ((i == 8) || (i == 16))) fd_bad = 1'b1;
      if (i == 8) lv = 1'b0;
      step();
    end
    check("b2b_stream", got16, 16'hF00F);
    check("b2b_valid", valid_all, 1);
    check("b2b_frame_done", fd_bad, 0);

    // Async reset during the 3rd bit of 8'hFF.
    sel = 0; ld = 8'hFF; lv = 1'b1;
    step();                       // cycle N+1
    lv = 1'b0;
    step();
    step();                       // cycle N+3
    check("ar_bit3", {ia.sd_valid, ia.sd}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    check("ar_sd", ia.sd, 0);
    check("ar_sd_valid", ia.sd_valid, 0);
    check("ar_busy", ia.busy, 0);
    check("ar_ready", ia.load_ready, 1);
    step();
    rst_n = 1'b1;
    fd_any = 1'b0;
    for (int i = 0; i < 12; i++) begin
      fd_any = fd_any | ia.frame_done;
      step();
    end
    check("ar_no_frame_done", fd_any, 0);
    run_word(0, 8'h81, 8'b1000_0001);
    step();

    // Integration: delay line reproduces sd four edges later.
    sel = 0; ld = 8'h80; lv = 1'b1;
    step();                       // cycle N+1, first bit on sd
    lv = 1'b0;
    check("int_first_bit", ia.sd, 1);
    q_early = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      q_early = q_early | q;
    end
    check("int_q_early", q_early, 0);
    step();                       // after 4th edge
    check("int_q", q, 1);
    check("int_q_n", q_n, 0);
    step();
    check("int_q_next", q, 0);
    repeat (10) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_piso_serializer
